// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between an instruction-fetch port
// and a data port; each response is steered back to whichever port issued the request.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ireq_val,
  output logic        ireq_rdy,
  input  logic [31:0] ireq_addr,
  output logic        iresp_val,
  output logic [31:0] iresp_data,
  input  logic        dreq_val,
  output logic        dreq_rdy,
  input  logic        dreq_type,
  input  logic [31:0] dreq_addr,
  input  logic [31:0] dreq_wdata,
  output logic        dresp_val,
  output logic [31:0] dresp_data,
  output logic        memreq_val,
  output logic        memreq_type,
  output logic [31:0] memreq_addr,
  output logic [31:0] memreq_wdata,
  input  logic [31:0] memresp_rdata,
  output logic [15:0] conflict_count
);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  localparam logic [2:0] LatCnt = 3'(MEM_LAT);
  localparam logic       PortI  = 1'b0;
  localparam logic       PortD  = 1'b1;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        owner_type_q, owner_type_d;
  logic        prio_q, prio_d;
  logic [15:0] conflict_q, conflict_d;

  logic resp_cycle, grant_ok, both_val, grant_i, grant_d;

  // Everything is qualified with rst so outputs drop to zero the moment reset asserts.
  always_comb begin
    resp_cycle = rst && (state_q == StWait) && (cnt_q == LatCnt);
    grant_ok   = rst && ((state_q == StIdle) || resp_cycle);
    both_val   = ireq_val && dreq_val;
    grant_i    = grant_ok && ireq_val && (!dreq_val || (prio_q == PortI));
    grant_d    = grant_ok && dreq_val && (!ireq_val || (prio_q == PortD));
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    owner_type_d = owner_type_q;
    prio_d       = prio_q;
    conflict_d   = conflict_q;
    if ((state_q == StWait) && (cnt_q < LatCnt)) begin
      cnt_d = cnt_q + 3'd1;
    end
    if (grant_i || grant_d) begin
      state_d      = StWait;
      cnt_d        = 3'd1;
      owner_d      = grant_d;
      owner_type_d = grant_d && dreq_type;
      prio_d       = grant_i;  // loser gets priority next time
      if (both_val && (conflict_q != 16'hFFFF)) begin
        conflict_d = conflict_q + 16'd1;
      end
    end else if (resp_cycle) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= 3'd0;
      owner_q      <= PortI;
      owner_type_q <= 1'b0;
      prio_q       <= PortD;
      conflict_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      owner_type_q <= owner_type_d;
      prio_q       <= prio_d;
      conflict_q   <= conflict_d;
    end
  end

  always_comb begin
    ireq_rdy     = grant_i;
    dreq_rdy     = grant_d;
    memreq_val   = grant_i || grant_d;
    memreq_type  = grant_d && dreq_type;
    memreq_addr  = 32'd0;
    memreq_wdata = 32'd0;
    if (grant_d) begin
      memreq_addr  = dreq_addr;
      memreq_wdata = dreq_wdata;
    end else if (grant_i) begin
      memreq_addr  = ireq_addr;
    end
    iresp_val  = resp_cycle && (owner_q == PortI);
    dresp_val  = resp_cycle && (owner_q == PortD);
    iresp_data = iresp_val ? memresp_rdata : 32'd0;
    dresp_data = (dresp_val && !owner_type_q) ? memresp_rdata : 32'd0;
    conflict_count = conflict_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised scoreboard bench for mem_port_arbiter: a latency-3 instance checked against a
// grant/priority/memory reference model, plus a latency-1 instance driven into counter saturation.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        rst_m;
  logic        ireq_val, ireq_rdy, iresp_val;
  logic [31:0] ireq_addr, iresp_data;
  logic        dreq_val, dreq_rdy, dreq_type, dresp_val;
  logic [31:0] dreq_addr, dreq_wdata, dresp_data;
  logic        memreq_val, memreq_type;
  logic [31:0] memreq_addr, memreq_wdata, memresp_rdata;
  logic [15:0] conflict_count;

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .rst(rst_m),
    .ireq_val(ireq_val), .ireq_rdy(ireq_rdy), .ireq_addr(ireq_addr),
    .iresp_val(iresp_val), .iresp_data(iresp_data),
    .dreq_val(dreq_val), .dreq_rdy(dreq_rdy), .dreq_type(dreq_type),
    .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .dresp_val(dresp_val), .dresp_data(dresp_data),
    .memreq_val(memreq_val), .memreq_type(memreq_type), .memreq_addr(memreq_addr),
    .memreq_wdata(memreq_wdata), .memresp_rdata(memresp_rdata),
    .conflict_count(conflict_count)
  );

  // Saturation DUT: latency 1, both ports permanently requesting
  logic        s_rst;
  logic        s_one = 1'b1;
  logic        s_zero = 1'b0;
  logic [31:0] s_iaddr = 32'h0000_0200;
  logic [31:0] s_daddr = 32'h0000_2000;
  logic [31:0] s_rdata = 32'h0000_0013;
  logic        s_ireq_rdy, s_iresp_val, s_dreq_rdy, s_dresp_val;
  logic [31:0] s_iresp_data, s_dresp_data, s_mem_addr, s_mem_wdata;
  logic        s_mem_val, s_mem_type;
  logic [15:0] s_conflict;

  mem_port_arbiter #(.MEM_LAT(1)) dut_sat (
    .clk(clk), .rst(s_rst),
    .ireq_val(s_one), .ireq_rdy(s_ireq_rdy), .ireq_addr(s_iaddr),
    .iresp_val(s_iresp_val), .iresp_data(s_iresp_data),
    .dreq_val(s_one), .dreq_rdy(s_dreq_rdy), .dreq_type(s_zero),
    .dreq_addr(s_daddr), .dreq_wdata(s_iaddr),
    .dresp_val(s_dresp_val), .dresp_data(s_dresp_data),
    .memreq_val(s_mem_val), .memreq_type(s_mem_type), .memreq_addr(s_mem_addr),
    .memreq_wdata(s_mem_wdata), .memresp_rdata(s_rdata),
    .conflict_count(s_conflict)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;
  bit          sat_done = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Environment memory: fixed read latency LAT, garbage on non-read cycles
  logic [31:0] env_mem [bit [31:0]];
  logic [31:0] dly [1:LAT];
  initial for (int k = 1; k <= LAT; k++) dly[k] = 32'd0;
  always @(posedge clk) begin
    if (memreq_val && memreq_type) env_mem[memreq_addr] = memreq_wdata;
    if (memreq_val && !memreq_type)
      dly[1] <= env_mem.exists(memreq_addr) ? env_mem[memreq_addr] : init_word(memreq_addr);
    else
      dly[1] <= $urandom();
    for (int k = 2; k <= LAT; k++) dly[k] <= dly[k-1];
  end
  assign memresp_rdata = dly[LAT];

  // Reference model: sequential memory plus round-robin rule and busy window
  typedef struct {
    int unsigned cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] ref_mem [bit [31:0]];
  bit          prio_d_m;
  int unsigned free_cyc;
  logic [15:0] conf_m;
  logic        allowed, exp_i, exp_d;
  exp_t        e;

  always @(negedge clk) begin
    if (!rst_m) begin
      prio_d_m = 1'b1;
      free_cyc = 0;
      conf_m   = 16'd0;
      iq.delete();
      dq.delete();
    end else begin
      chk("conflict_count", conflict_count, conf_m);
      allowed = (cyc >= free_cyc);
      exp_i   = allowed && ireq_val && (!dreq_val || !prio_d_m);
      exp_d   = allowed && dreq_val && (!ireq_val || prio_d_m);
      chk("ireq_rdy", ireq_rdy, exp_i);
      chk("dreq_rdy", dreq_rdy, exp_d);
      chk("memreq_val", memreq_val, exp_i || exp_d);
      if (exp_d) begin
        chk("memreq_type_d", memreq_type, dreq_type);
        chk("memreq_addr_d", memreq_addr, dreq_addr);
        chk("memreq_wdata_d", memreq_wdata, dreq_wdata);
        e.cyc = cyc + LAT;
        if (dreq_type) begin
          ref_mem[dreq_addr] = dreq_wdata;
          e.data = 32'd0;
        end else begin
          e.data = ref_mem.exists(dreq_addr) ? ref_mem[dreq_addr] : init_word(dreq_addr);
        end
        dq.push_back(e);
      end else if (exp_i) begin
        chk("memreq_type_i", memreq_type, 0);
        chk("memreq_addr_i", memreq_addr, ireq_addr);
        chk("memreq_wdata_i", memreq_wdata, 0);
        e.cyc  = cyc + LAT;
        e.data = ref_mem.exists(ireq_addr) ? ref_mem[ireq_addr] : init_word(ireq_addr);
        iq.push_back(e);
      end else begin
        chk("memreq_idle_fields", memreq_addr | memreq_wdata | 32'(memreq_type), 0);
      end
      if (exp_i || exp_d) begin
        if (ireq_val && dreq_val && conf_m != 16'hFFFF) conf_m = conf_m + 16'd1;
        prio_d_m = exp_i;
        free_cyc = cyc + LAT;
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (rst_m) begin
      if (iresp_val) begin
        if (iq.size() == 0) fail("iresp_unexpected");
        else begin
          chk("iresp_cycle", cyc, iq[0].cyc);
          chk("iresp_data", iresp_data, iq[0].data);
          iq.delete(0);
        end
      end else begin
        chk("iresp_data_idle", iresp_data, 0);
        if (iq.size() > 0 && iq[0].cyc <= cyc) begin
          fail("iresp_missing");
          iq.delete(0);
        end
      end
      if (dresp_val) begin
        if (dq.size() == 0) fail("dresp_unexpected");
        else begin
          chk("dresp_cycle", cyc, dq[0].cyc);
          chk("dresp_data", dresp_data, dq[0].data);
          dq.delete(0);
        end
      end else begin
        chk("dresp_data_idle", dresp_data, 0);
        if (dq.size() > 0 && dq[0].cyc <= cyc) begin
          fail("dresp_missing");
          dq.delete(0);
        end
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    return 32'h0000_2000 + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
  endfunction

  // One cycle of requester behaviour: hold until accepted, then maybe issue a new request
  task automatic cycle_drive(input int unsigned pi, input int unsigned pd);
    logic i_acc, d_acc;
    @(negedge clk);
    i_acc = ireq_val && ireq_rdy;
    d_acc = dreq_val && dreq_rdy;
    @(posedge clk);
    #1;
    if (!ireq_val || i_acc) begin
      ireq_val  = ($urandom_range(0, 99) < pi);
      ireq_addr = rand_addr();
    end
    if (!dreq_val || d_acc) begin
      dreq_val   = ($urandom_range(0, 99) < pd);
      dreq_type  = 1'($urandom_range(0, 1));
      dreq_addr  = rand_addr();
      dreq_wdata = $urandom();
    end
  endtask

  initial begin
    logic got;
    rst_m = 1'b0;
    ireq_val = 1'b0; ireq_addr = 32'd0;
    dreq_val = 1'b0; dreq_type = 1'b0; dreq_addr = 32'd0; dreq_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    ireq_val = 1'b1;
    dreq_val = 1'b1;
    #1;
    chk("reset_rdy", {ireq_rdy, dreq_rdy}, 0);
    chk("reset_vals", {memreq_val, iresp_val, dresp_val}, 0);
    chk("reset_count", conflict_count, 0);
    ireq_val = 1'b0;
    dreq_val = 1'b0;
    @(posedge clk);
    #1 rst_m = 1'b1;

    // Both ports request right after reset: D must go first
    @(posedge clk);
    #1;
    ireq_val = 1'b1; ireq_addr = 32'h0000_0200;
    dreq_val = 1'b1; dreq_type = 1'b0; dreq_addr = 32'h0000_2000; dreq_wdata = 32'd0;
    repeat (12) cycle_drive(0, 0);

    // Write then read back
    dreq_val = 1'b1; dreq_type = 1'b1; dreq_addr = 32'h0000_2004; dreq_wdata = 32'hDEAD_BEEF;
    repeat (8) cycle_drive(0, 0);
    dreq_val = 1'b1; dreq_type = 1'b0; dreq_addr = 32'h0000_2004;
    repeat (8) cycle_drive(0, 0);

    // Continuous contention
    ireq_val = 1'b1; ireq_addr = rand_addr();
    dreq_val = 1'b1; dreq_type = 1'b0; dreq_addr = rand_addr();
    repeat (8 * LAT) cycle_drive(100, 100);
    repeat (12) cycle_drive(0, 0);

    // Reset one cycle after a data read grant; its response must never appear
    dreq_val = 1'b1; dreq_type = 1'b0; dreq_addr = 32'h0000_2008;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = dreq_rdy;
    end
    if (!got) fail("reset_phase_grant_timeout");
    @(posedge clk);
    #1;
    dreq_val = 1'b0;
    rst_m    = 1'b0;
    #1;
    chk("midrst_vals", {ireq_rdy, dreq_rdy, memreq_val, memreq_type, iresp_val, dresp_val}, 0);
    chk("midrst_mem_fields", memreq_addr | memreq_wdata, 0);
    chk("midrst_resp_data", iresp_data | dresp_data, 0);
    chk("midrst_count", conflict_count, 0);
    @(posedge clk);
    #1 rst_m = 1'b1;
    ireq_val = 1'b1; ireq_addr = rand_addr();
    dreq_val = 1'b1; dreq_type = 1'b0; dreq_addr = rand_addr();
    repeat (12) cycle_drive(0, 0);

    // Random traffic
    for (int s = 0; s < 15; s++) begin
      int unsigned pi, pd;
      pi = $urandom_range(0, 100);
      pd = $urandom_range(0, 100);
      repeat (100) cycle_drive(pi, pd);
    end
    repeat (12) cycle_drive(0, 0);
    chk("iq_drained", iq.size(), 0);
    chk("dq_drained", dq.size(), 0);

    wait (sat_done);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Saturation instance: grants every cycle, alternating D,I,...
  initial begin
    s_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 s_rst = 1'b1;
    for (int k = 1; k <= 66000; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        chk("sat_dreq_rdy", s_dreq_rdy, 32'(k % 2 == 1));
        chk("sat_ireq_rdy", s_ireq_rdy, 32'(k % 2 == 0));
      end
      if (k >= 2 && k <= 8) begin
        chk("sat_dresp_val", s_dresp_val, 32'(k % 2 == 0));
        chk("sat_iresp_val", s_iresp_val, 32'(k % 2 == 1));
        chk("sat_dresp_data", s_dresp_data, (k % 2 == 0) ? 32'h13 : 32'h0);
        chk("sat_iresp_data", s_iresp_data, (k % 2 == 1) ? 32'h13 : 32'h0);
      end
      if (k == 1000) chk("sat_count_mid", s_conflict, 999);
    end
    chk("sat_count_saturated", s_conflict, 16'hFFFF);
    sat_done = 1'b1;
  end

endmodule
